uart_rx_engine: RTL

- Serial receive side of the UART: detects a start bit, samples data, parity and stop bits at bit-centre, and presents a parallel byte with ready/error flags to the host register interface.
- Mirrors the transmit path's k-based bit timing: one bit period = k+1 clk cycles.
- Uses an internal bit-time counter that supports both half-bit and full-bit terminal counts.

---
 rtl/uart_rx_engine_pkg.sv | 28 ++
 rtl/uart_rx_bit_timer.sv | 33 +++
 rtl/uart_rx_engine.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_engine_pkg.sv
// Shared definitions for the UART receive engine: FSM state encoding,
// default widths, parity-sense constants and the parity-check helper.
package uart_rx_engine_pkg;

    localparam int K_W    = 19;
    localparam int DATA_W = 8;

    // Parity sense as carried on the ohel input.
    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // data_par is the XOR of all received data bits.
    // Even sense flags an odd total; odd sense flags an even total.
    function automatic logic parity_error(input logic data_par,
                                          input logic par_bit,
                                          input logic sense);
        return (data_par ^ par_bit) ^ (sense == ODD);
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-time counter for the UART receiver. Counts up from 0 while run is
// high; tc pulses when the count equals the target, and the count reloads
// to 0 on the following edge. Target is k (full bit) or k>>1 (half bit,
// selected with half_sel). Held at 0 while run is low.
module uart_rx_bit_timer #(
    parameter int K_W = uart_rx_engine_pkg::K_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic           half_sel,
    input  logic [K_W-1:0] k,
    output logic           tc
);

    logic [K_W-1:0] count;
    logic [K_W-1:0] target;

    assign target = half_sel ? (k >> 1) : k;
    assign tc     = run && (count == target);

    // Count towards the target, reload at terminal count, clear when idle.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count <= '0;
        end else if (count == target) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: start-bit qualification at half-bit, data/parity/stop
// sampling at bit centre, parallel byte presentation with ready, parity,
// framing and overrun flags.
// Optional build macro UART_RX_SYNC_EN: when defined, rx passes through a
// 2-flop synchronizer (reset value 1) ahead of the FSM, adding 2 cycles to
// every sample point. When undefined, rx must already be synchronous to clk.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line idle, timer held at 0, waiting for rx low
// START  | half-bit wait, then confirm start bit (low) or reject (high)
// DATA   | full-bit waits, shift in 7 or 8 data bits LSB first
// PARITY | full-bit wait, capture parity bit
// STOP   | full-bit wait, capture stop bit; next edge publishes the frame
module uart_rx_engine
    import uart_rx_engine_pkg::*;
#(
    parameter int K_W    = uart_rx_engine_pkg::K_W,
    parameter int DATA_W = uart_rx_engine_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic [K_W-1:0]    k,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic              clr_rdy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_rdy,
    output logic              perr,
    output logic              ferr,
    output logic              ovf
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_FULL  = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_SHORT = IDX_W'(DATA_W - 2);

    logic rx_line;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchronizer; idles high so reset does not look like a start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_line = sync_q[1];
`else
    assign rx_line = rx;
`endif

    rx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic              cfg_eight;
    logic              cfg_pen;
    logic              cfg_ohel;
    logic              par_bit;
    logic              stop_bit;
    logic              stop_seen;
    logic              tc;
    logic [DATA_W-1:0] frame_byte;
    logic              data_par;
    logic              last_bit;

    // In short frames the data sits in the upper bits of the shift register.
    assign frame_byte = cfg_eight ? shreg : {1'b0, shreg[DATA_W-1:1]};
    assign data_par   = ^frame_byte;
    assign last_bit   = (bit_idx == (cfg_eight ? LAST_FULL : LAST_SHORT));

    uart_rx_bit_timer #(
        .K_W (K_W)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (state != IDLE),
        .half_sel (state == START),
        .k        (k),
        .tc       (tc)
    );

    // Frame sequencing and host-visible flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            cfg_eight <= 1'b0;
            cfg_pen   <= 1'b0;
            cfg_ohel  <= EVEN;
            par_bit   <= 1'b0;
            stop_bit  <= 1'b0;
            stop_seen <= 1'b0;
            rx_data   <= '0;
            rx_rdy    <= 1'b0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            // Host read; a completing frame below overrides this.
            if (clr_rdy) begin
                rx_rdy <= 1'b0;
                ovf    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_line) begin
                        state <= START;
                    end
                end

                START: begin
                    if (tc) begin
                        if (!rx_line) begin
                            state     <= DATA;
                            cfg_eight <= eight;
                            cfg_pen   <= pen;
                            cfg_ohel  <= ohel;
                            bit_idx   <= '0;
                            shreg     <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                DATA: begin
                    if (tc) begin
                        shreg   <= {rx_line, shreg[DATA_W-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (last_bit) begin
                            state <= cfg_pen ? PARITY : STOP;
                        end
                    end
                end

                PARITY: begin
                    if (tc) begin
                        par_bit <= rx_line;
                        state   <= STOP;
                    end
                end

                STOP: begin
                    if (stop_seen) begin
                        // Leave mid-stop-bit so a back-to-back start is caught.
                        stop_seen <= 1'b0;
                        rx_data   <= frame_byte;
                        perr      <= cfg_pen && parity_error(data_par, par_bit, cfg_ohel);
                        ferr      <= ~stop_bit;
                        rx_rdy    <= 1'b1;
                        ovf       <= clr_rdy ? 1'b0 : (ovf | rx_rdy);
                        state     <= IDLE;
                    end else if (tc) begin
                        stop_bit  <= rx_line;
                        stop_seen <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
